// File: rtl/branch_predictor.sv
// Bimodal branch predictor: direct-mapped table of 2-bit saturating counters,
// combinational decode lookup, execute-stage training, registered mispredict redirect.

module bp_ctr #(
  parameter logic [1:0] INIT_CNT = 2'b01
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       upd,
  input  logic       taken,
  output logic [1:0] cnt
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= INIT_CNT;
    else if (upd) begin
      if (taken)
        cnt <= (cnt == 2'd3) ? 2'd3 : cnt + 2'd1;
      else
        cnt <= (cnt == 2'd0) ? 2'd0 : cnt - 2'd1;
    end
  end
endmodule

module branch_predictor #(
  parameter int         IDX_W    = 6,
  parameter logic [1:0] INIT_CNT = 2'b01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] id_pc,
  input  logic        id_branch,
  output logic        id_pred_taken,
  input  logic        ex_valid,
  input  logic        ex_kill,
  input  logic [31:0] ex_pc,
  input  logic        ex_pred_taken,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic [31:0] br_cnt,
  output logic [31:0] miss_cnt
);
  localparam int ENTRIES = 1 << IDX_W;

  logic [ENTRIES-1:0][1:0] tbl;
  logic [ENTRIES-1:0]      upd;
  logic [IDX_W-1:0]        id_idx;
  logic [IDX_W-1:0]        ex_idx;
  logic                    eff;
  logic                    miss;

  assign id_idx = id_pc[IDX_W+1:2];
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign eff    = ex_valid & ~ex_kill;
  assign miss   = eff & (ex_taken != ex_pred_taken);

  // Tag-less lookup: aliasing PCs share an entry by design.
  assign id_pred_taken = id_branch & tbl[id_idx][1];

  // One-hot write enable; gated by eff so X on ex_* cannot disturb the table.
  always_comb begin
    upd = '0;
    if (eff) upd[ex_idx] = 1'b1;
  end

  genvar g;
  generate
    for (g = 0; g < ENTRIES; g++) begin : g_ent
      bp_ctr #(.INIT_CNT(INIT_CNT)) u_ctr (
        .clk  (clk),
        .rst  (rst),
        .upd  (upd[g]),
        .taken(ex_taken),
        .cnt  (tbl[g])
      );
    end
  endgenerate

  // Redirect skips the delay slot on a not-taken correction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect    <= 1'b0;
      redirect_pc <= '0;
    end else begin
      redirect <= miss;
      if (miss)
        redirect_pc <= ex_taken ? ex_target : ex_pc + 32'd8;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_cnt   <= '0;
      miss_cnt <= '0;
    end else begin
      if (eff && br_cnt != 32'hFFFF_FFFF)    br_cnt   <= br_cnt + 32'd1;
      if (miss && miss_cnt != 32'hFFFF_FFFF) miss_cnt <= miss_cnt + 32'd1;
    end
  end

  logic unused_pc_bits;
  assign unused_pc_bits = ^{id_pc[31:IDX_W+2], id_pc[1:0], ex_pc[31:IDX_W+2], ex_pc[1:0]};
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor with hand-computed expectations.

module tb_branch_predictor;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] id_pc;
  logic        id_branch;
  logic        id_pred_taken;
  logic        ex_valid, ex_kill, ex_pred_taken, ex_taken;
  logic [31:0] ex_pc, ex_target;
  logic        redirect;
  logic [31:0] redirect_pc, br_cnt, miss_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk          (clk),
    .rst          (rst),
    .id_pc        (id_pc),
    .id_branch    (id_branch),
    .id_pred_taken(id_pred_taken),
    .ex_valid     (ex_valid),
    .ex_kill      (ex_kill),
    .ex_pc        (ex_pc),
    .ex_pred_taken(ex_pred_taken),
    .ex_taken     (ex_taken),
    .ex_target    (ex_target),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .br_cnt       (br_cnt),
    .miss_cnt     (miss_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive one resolving branch for a single edge; returns just after that edge.
  task automatic resolve(input logic [31:0] pc, input logic pred, input logic tk,
                         input logic [31:0] tgt, input logic kill);
    @(negedge clk);
    ex_valid = 1'b1; ex_kill = kill; ex_pc = pc;
    ex_pred_taken = pred; ex_taken = tk; ex_target = tgt;
    @(posedge clk); #1;
    ex_valid = 1'b0; ex_kill = 1'b0;
  endtask

  task automatic look(input string tag, input logic [31:0] pc, input logic exp);
    id_pc = pc; id_branch = 1'b1; #1;
    chk(tag, {31'd0, id_pred_taken}, {31'd0, exp});
  endtask

  task automatic stats(input string tag, input logic [31:0] b, input logic [31:0] m);
    chk({tag, "_br"}, br_cnt, b);
    chk({tag, "_miss"}, miss_cnt, m);
  endtask

  initial begin
    rst = 1'b1; id_pc = 32'h0; id_branch = 1'b0;
    ex_valid = 1'b0; ex_kill = 1'b0; ex_pc = 32'h0;
    ex_pred_taken = 1'b0; ex_taken = 1'b0; ex_target = 32'h0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // 1: reset state
    look("rst_pred", 32'h0040_0010, 1'b0);
    look("rst_pred2", 32'h0040_00FC, 1'b0);
    stats("rst", 0, 0);
    chk("rst_redir", {31'd0, redirect}, 0);
    chk("rst_rpc", redirect_pc, 0);

    // 2: two taken mispredicts on 0x00400010
    resolve(32'h0040_0010, 1'b0, 1'b1, 32'h0040_0100, 1'b0);
    chk("t2_redir1", {31'd0, redirect}, 1);
    chk("t2_rpc1", redirect_pc, 32'h0040_0100);
    resolve(32'h0040_0010, 1'b0, 1'b1, 32'h0040_0200, 1'b0);
    chk("t2_redir2", {31'd0, redirect}, 1);
    chk("t2_rpc2", redirect_pc, 32'h0040_0200);
    @(posedge clk); #1;
    chk("t2_redir_drop", {31'd0, redirect}, 0);
    look("t2_pred", 32'h0040_0010, 1'b1);
    id_branch = 1'b0; #1;
    chk("t2_nobranch", {31'd0, id_pred_taken}, 0);
    stats("t2", 2, 2);

    // 3: saturate at 3, then step down
    for (int i = 0; i < 5; i++) resolve(32'h0040_0020, 1'b1, 1'b1, 32'h0040_0300, 1'b0);
    chk("t3_no_redir", {31'd0, redirect}, 0);
    stats("t3a", 7, 2);
    resolve(32'h0040_0020, 1'b1, 1'b0, 32'h0040_0300, 1'b0);
    chk("t3_redir", {31'd0, redirect}, 1);
    chk("t3_rpc", redirect_pc, 32'h0040_0028);
    look("t3_pred_after1", 32'h0040_0020, 1'b1);
    resolve(32'h0040_0020, 1'b1, 1'b0, 32'h0040_0300, 1'b0);
    look("t3_pred_after2", 32'h0040_0020, 1'b0);
    stats("t3b", 9, 4);

    // 4: fall-through PC wraps
    resolve(32'hFFFF_FFFC, 1'b1, 1'b0, 32'h1234_5678, 1'b0);
    chk("t4_redir", {31'd0, redirect}, 1);
    chk("t4_rpc", redirect_pc, 32'h0000_0004);
    @(posedge clk); #1;
    chk("t4_pulse", {31'd0, redirect}, 0);
    chk("t4_rpc_hold", redirect_pc, 32'h0000_0004);
    stats("t4", 10, 5);

    // 5: same-cycle lookup/update, then killed update
    @(negedge clk);
    id_pc = 32'h0040_0040; id_branch = 1'b1;
    ex_valid = 1'b1; ex_kill = 1'b0; ex_pc = 32'h0040_0040;
    ex_pred_taken = 1'b0; ex_taken = 1'b1; ex_target = 32'h0040_0400;
    #1 chk("t5_old", {31'd0, id_pred_taken}, 0);
    ex_taken = 1'b1; ex_pred_taken = 1'b0;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    chk("t5_new", {31'd0, id_pred_taken}, 1);
    chk("t5_rpc", redirect_pc, 32'h0040_0400);
    resolve(32'h0040_0040, 1'b1, 1'b0, 32'h0040_0500, 1'b1);
    chk("t5_kill_redir", {31'd0, redirect}, 0);
    chk("t5_kill_rpc", redirect_pc, 32'h0040_0400);
    look("t5_kill_pred", 32'h0040_0040, 1'b1);
    stats("t5", 11, 6);
    @(negedge clk);
    ex_pc = 'x; ex_taken = 1'bx; ex_pred_taken = 1'bx; ex_target = 'x;
    @(posedge clk); #1;
    chk("t5_x_rpc", redirect_pc, 32'h0040_0400);
    stats("t5x", 11, 6);

    // 6: async reset between edges, then aliasing
    resolve(32'h0040_0050, 1'b0, 1'b1, 32'h0040_0600, 1'b0);
    chk("t6_pre_redir", {31'd0, redirect}, 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_redir", {31'd0, redirect}, 0);
    chk("t6_rst_rpc", redirect_pc, 0);
    stats("t6_rst", 0, 0);
    look("t6_rst_pred", 32'h0040_0010, 1'b0);
    #1 rst = 1'b0;
    resolve(32'h0040_0110, 1'b0, 1'b1, 32'h0040_0700, 1'b0);
    look("t6_alias", 32'h0040_0010, 1'b1);
    stats("t6", 1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=%0d exp=%0d", 1, 0);
    $fatal(1);
  end
endmodule
